// File: rtl/serializador_fila.sv
// serializador_fila
//   Pulls bytes one at a time from an external queue and shifts each one out
//   MSB first on serial_out. Every byte is followed by a handshake: the block
//   waits in WAIT_ACK until downstream acknowledges. Only then does it count
//   the byte and go back to IDLE.
//
// Ports
//   clock_10khz     in   1  system clock, rising edge
//   reset           in   1  asynchronous, active-high
//   enable_in       in   1  permits starting a new byte transfer
//   len_in          in   8  queue occupancy (queue len_out)
//   data_in         in   8  queue read data (queue data_out)
//   ack_in          in   1  downstream acknowledge of a completed byte
//   dequeue_out     out  1  one-cycle dequeue request (queue dequeue_in)
//   serial_out      out  1  serial data bit, MSB first
//   valid_out       out  1  serial_out carries a valid bit
//   done_out        out  1  byte fully shifted, awaiting ack_in
//   busy_out        out  1  transfer in progress
//   sent_count_out  out  8  acknowledged byte count, wraps at 256
//
// Timing per byte, counted from the REQ cycle (cycle 0):
//   0 REQ, 1 LOAD, 2..9 SHIFT, 10.. WAIT_ACK, then one IDLE cycle.
//   With ack_in already high, dequeue pulses are 12 cycles apart.

module serializador_fila (
    input  logic       clock_10khz,
    input  logic       reset,
    input  logic       enable_in,
    input  logic [7:0] len_in,
    input  logic [7:0] data_in,
    input  logic       ack_in,
    output logic       dequeue_out,
    output logic       serial_out,
    output logic       valid_out,
    output logic       done_out,
    output logic       busy_out,
    output logic [7:0] sent_count_out
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_SHIFT    = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK = 3'd4;

    logic [2:0] state_q,      state_d;
    logic [7:0] shift_reg_q,  shift_reg_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [7:0] sent_count_q, sent_count_d;

    always_comb begin
        state_d      = state_q;
        shift_reg_d  = shift_reg_q;
        bit_cnt_d    = bit_cnt_q;
        sent_count_d = sent_count_q;

        case (state_q)
            ST_IDLE: begin
                // len_in is looked at only here. Later changes cannot
                // disturb a transfer that has already started.
                if (enable_in && (len_in != '0)) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                // The queue shows the dequeued byte in the cycle after the
                // dequeue pulse, which is this cycle.
                shift_reg_d = data_in;
                bit_cnt_d   = '0;
                state_d     = ST_SHIFT;
            end

            ST_SHIFT: begin
                shift_reg_d = {shift_reg_q[6:0], 1'b0};
                bit_cnt_d   = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                if (ack_in) begin
                    sent_count_d = sent_count_q + 8'd1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_10khz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shift_reg_q  <= '0;
            bit_cnt_q    <= '0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            sent_count_q <= sent_count_d;
        end
    end

    // Outputs decode registered state only. No input reaches an output
    // combinationally.
    assign dequeue_out    = (state_q == ST_REQ);
    assign valid_out      = (state_q == ST_SHIFT);
    assign serial_out     = (state_q == ST_SHIFT) && shift_reg_q[7];
    assign done_out       = (state_q == ST_WAIT_ACK);
    assign busy_out       = (state_q != ST_IDLE);
    assign sent_count_out = sent_count_q;

endmodule
